// File: rtl/i2c_scl_gen.sv
// Open-drain I2C SCL generator with clock stretching, multi-master clock
// synchronisation, a stretch timeout and SDA change/sample strobes.
module i2c_scl_gen #(
   parameter int DIV_LEN     = 16,
   parameter int SYNC_STAGES = 2,   // must be >= 2
   parameter int TO_LEN      = 20
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               en,
   input  logic [DIV_LEN-1:0] low_len,
   input  logic [DIV_LEN-1:0] high_len,
   input  logic               timeout_clr,
   inout  wire                scl,
   output logic               busy,
   output logic               fall_tick,
   output logic               data_tick,
   output logic               rise_tick,
   output logic               sample_tick,
   output logic               stretching,
   output logic               timeout,
   output logic [DIV_LEN-1:0] counter,
   output logic [1:0]         state_dbg
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOW       = 2'd1,
      HIGH_WAIT = 2'd2,
      HIGH      = 2'd3
   } state_t;

   localparam logic [TO_LEN-1:0]  SYNC_CNT = TO_LEN'(SYNC_STAGES);
   localparam logic [DIV_LEN-1:0] ONE      = DIV_LEN'(1);

   state_t                   state_q, state_d;
   logic [DIV_LEN-1:0]       cnt_q, cnt_d;
   logic [TO_LEN-1:0]        wcnt_q, wcnt_d;
   logic [DIV_LEN-1:0]       low_q, low_d, high_q, high_d;
   logic [DIV_LEN-1:0]       low_eff, high_eff;
   logic                     timeout_q, timeout_d;
   logic                     drive_low_q;
   logic [SYNC_STAGES-1:0]   sync_q;
   logic                     scl_s;

   assign scl   = drive_low_q ? 1'b0 : 1'bz;
   assign scl_s = sync_q[SYNC_STAGES-1];

   assign low_eff  = (low_len == '0)  ? ONE : low_len;
   assign high_eff = (high_len == '0) ? ONE : high_len;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wcnt_d    = '0;
      low_d     = low_q;
      high_d    = high_q;
      timeout_d = timeout_q;
      if (timeout_clr)
         timeout_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (en && !timeout_q && scl_s) begin
               state_d = LOW;
               cnt_d   = '0;
               low_d   = low_eff;
               high_d  = high_eff;
            end
         end
         LOW: begin
            if (cnt_q == low_q - 1'b1) begin
               state_d = HIGH_WAIT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         HIGH_WAIT: begin
            wcnt_d = wcnt_q + 1'b1;
            // A release cannot be seen before the synchroniser has flushed the
            // low level, so earlier highs are stale (matters for very short LOW).
            if (scl_s && wcnt_q >= SYNC_CNT) begin
               state_d = HIGH;
               wcnt_d  = '0;
            end else if (wcnt_d == '1) begin
               state_d   = IDLE;
               timeout_d = 1'b1;
               wcnt_d    = '0;
            end
         end
         HIGH: begin
            if (cnt_q == high_q - 1'b1) begin
               cnt_d = '0;
               if (en) begin
                  state_d = LOW;
                  low_d   = low_eff;
                  high_d  = high_eff;
               end else begin
                  state_d = IDLE;
               end
            end else if (!scl_s) begin
               state_d = LOW;
               cnt_d   = '0;
               low_d   = low_eff;
               high_d  = high_eff;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         wcnt_q      <= '0;
         low_q       <= ONE;
         high_q      <= ONE;
         timeout_q   <= 1'b0;
         drive_low_q <= 1'b0;
         sync_q      <= '1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wcnt_q      <= wcnt_d;
         low_q       <= low_d;
         high_q      <= high_d;
         timeout_q   <= timeout_d;
         drive_low_q <= (state_d == LOW);
         sync_q      <= {sync_q[SYNC_STAGES-2:0], scl};
      end
   end

   // Midpoint strobes yield to the entry strobes when a phase is one cycle long;
   // sampling is skipped once another master has pulled the line low.
   assign busy        = (state_q != IDLE);
   assign fall_tick   = (state_q == LOW)  && (cnt_q == '0);
   assign rise_tick   = (state_q == HIGH) && (cnt_q == '0);
   assign data_tick   = (state_q == LOW)  && (cnt_q != '0) && (cnt_q == (low_q >> 1));
   assign sample_tick = (state_q == HIGH) && (cnt_q != '0) && (cnt_q == (high_q >> 1)) && scl_s;
   assign stretching  = (state_q == HIGH_WAIT) && (wcnt_q > SYNC_CNT);
   assign timeout     = timeout_q;
   assign counter     = cnt_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_i2c_scl_gen.sv
// Bench for i2c_scl_gen: tick events are scoreboarded as {kind, cycles since
// previous tick}; status outputs are checked directly at known cycles.
module tb_i2c_scl_gen;

   localparam int DW = 16;
   localparam int W  = 16;

   localparam logic [3:0] T_FALL = 4'b1000;
   localparam logic [3:0] T_DATA = 4'b0100;
   localparam logic [3:0] T_RISE = 4'b0010;
   localparam logic [3:0] T_SAMP = 4'b0001;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          en_a = 1'b0, en_b = 1'b0;
   logic          clr_a = 1'b0, clr_b = 1'b0;
   logic [DW-1:0] low_len = 16'd4, high_len = 16'd4;
   logic          hold_a = 1'b0, hold_b = 1'b0;
   wire           scl_a, scl_b;

   logic          busy_a, fall_a, data_a, rise_a, samp_a, str_a, to_a;
   logic          busy_b, fall_b, data_b, rise_b, samp_b, str_b, to_b;
   logic [DW-1:0] cnt_a, cnt_b;
   logic [1:0]    st_a, st_b;

   pullup (scl_a);
   pullup (scl_b);
   assign scl_a = hold_a ? 1'b0 : 1'bz;
   assign scl_b = hold_b ? 1'b0 : 1'bz;

   i2c_scl_gen #(.DIV_LEN(DW), .SYNC_STAGES(2), .TO_LEN(20)) dut (
      .clk(clk), .rstn(rstn), .en(en_a), .low_len(low_len), .high_len(high_len),
      .timeout_clr(clr_a), .scl(scl_a), .busy(busy_a), .fall_tick(fall_a),
      .data_tick(data_a), .rise_tick(rise_a), .sample_tick(samp_a),
      .stretching(str_a), .timeout(to_a), .counter(cnt_a), .state_dbg(st_a)
   );

   i2c_scl_gen #(.DIV_LEN(DW), .SYNC_STAGES(2), .TO_LEN(4)) dut_to (
      .clk(clk), .rstn(rstn), .en(en_b), .low_len(low_len), .high_len(high_len),
      .timeout_clr(clr_b), .scl(scl_b), .busy(busy_b), .fall_tick(fall_b),
      .data_tick(data_b), .rise_tick(rise_b), .sample_tick(samp_b),
      .stretching(str_b), .timeout(to_b), .counter(cnt_b), .state_dbg(st_b)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, expected finish before 200000");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   int ref_cyc = 0;
   int n_cmp = 0;
   int n_err = 0;

   task automatic expect_tick(input logic [3:0] kind, input int delta);
      exp_q.push_back({kind, 12'(delta)});
   endtask

   task automatic mark();
      ref_cyc = cyc;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin : monitor
      logic [3:0]   kind;
      logic [W-1:0] act;
      logic [W-1:0] exp;
      kind = {fall_a, data_a, rise_a, samp_a};
      if (kind != 4'b0000) begin
         act     = {kind, 12'(cyc - ref_cyc)};
         ref_cyc = cyc;
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL tick_unexpected: got kind=%b delta=%0d, expected no tick", act[15:12], act[11:0]);
         end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
               n_err++;
               $display("FAIL tick: got kind=%b delta=%0d, expected kind=%b delta=%0d",
                        act[15:12], act[11:0], exp[15:12], exp[11:0]);
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_drained(input string name);
      check(name, exp_q.size(), 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rstn = 1'b0;
      step(3);
      check("rst_busy", busy_a, 0);
      check("rst_ticks", {fall_a, data_a, rise_a, samp_a}, 0);
      check("rst_counter", cnt_a, 0);
      check("rst_timeout", to_a, 0);
      check("rst_stretch", str_a, 0);
      check("rst_scl", scl_a, 1);
      check("rst_state", st_a, 0);
      rstn = 1'b1;
      step(2);

      // Free-running 4/4 with pull-up only; en dropped mid-LOW of period 3.
      low_len = 16'd4; high_len = 16'd4; en_a = 1'b1; mark();
      for (int p = 0; p < 3; p++) begin
         expect_tick(T_FALL, (p == 0) ? 1 : 2);
         expect_tick(T_DATA, 2);
         expect_tick(T_RISE, 5);
         expect_tick(T_SAMP, 2);
      end
      step(1);
      check("t1_scl_low", scl_a, 0);
      check("t1_cnt0", cnt_a, 0);
      step(3);
      check("t1_cnt3", cnt_a, 3);
      step(1);
      check("t1_hw_state", st_a, 2);
      check("t1_hw_cnt", cnt_a, 0);
      check("t1_hw_scl", scl_a, 1);
      step(2);
      check("t1_hw_nostretch", str_a, 0);
      step(17);
      check("t1_p3_low", st_a, 1);
      en_a = 1'b0;
      step(12);
      check("t1_end_busy", busy_a, 0);
      check("t1_end_scl", scl_a, 1);
      step(15);
      check_drained("t1_drained");

      // Slave stretches 20 cycles beyond the master's release.
      en_a = 1'b1; mark();
      expect_tick(T_FALL, 1);
      expect_tick(T_DATA, 2);
      expect_tick(T_RISE, 25);
      expect_tick(T_SAMP, 2);
      step(2);
      hold_a = 1'b1;
      step(9);
      check("t2_stretch_early", str_a, 1);
      check("t2_cnt_hw", cnt_a, 0);
      en_a = 1'b0;
      step(14);
      check("t2_stretch_release", str_a, 1);
      hold_a = 1'b0;
      step(2);
      check("t2_still_wait", st_a, 2);
      step(1);
      check("t2_high", st_a, 3);
      check("t2_stretch_off", str_a, 0);
      check("t2_no_timeout", to_a, 0);
      step(8);
      check("t2_end_busy", busy_a, 0);
      check_drained("t2_drained");

      // Another master pulls SCL low at HIGH count 1.
      high_len = 16'd6; en_a = 1'b1; mark();
      expect_tick(T_FALL, 1);
      expect_tick(T_DATA, 2);
      expect_tick(T_RISE, 5);
      expect_tick(T_FALL, 4);
      expect_tick(T_DATA, 2);
      expect_tick(T_RISE, 5);
      expect_tick(T_SAMP, 3);
      step(8);
      check("t5_high_cnt0", cnt_a, 0);
      step(1);
      check("t5_high_cnt1", cnt_a, 1);
      hold_a = 1'b1;
      step(2);
      check("t5_cnt3", cnt_a, 3);
      step(1);
      check("t5_synced_low", st_a, 1);
      check("t5_scl_low", scl_a, 0);
      step(1);
      hold_a = 1'b0; en_a = 1'b0;
      step(12);
      check("t5_end_busy", busy_a, 0);
      step(4);
      check_drained("t5_drained");

      // Stuck-low SCL on the short-timeout instance.
      low_len = 16'd4; high_len = 16'd4; en_b = 1'b1;
      step(2);
      hold_b = 1'b1;
      step(17);
      check("t3_pre_timeout", to_b, 0);
      check("t3_pre_busy", busy_b, 1);
      check("t3_stretching", str_b, 1);
      step(1);
      check("t3_timeout", to_b, 1);
      check("t3_idle", busy_b, 0);
      check("t3_stretch_off", str_b, 0);
      step(1);
      hold_b = 1'b0;
      step(1);
      check("t3_released", scl_b, 1);
      step(9);
      check("t3_no_restart", busy_b, 0);
      check("t3_sticky", to_b, 1);
      clr_b = 1'b1;
      step(1);
      clr_b = 1'b0;
      check("t3_cleared", to_b, 0);
      check("t3_clr_idle", busy_b, 0);
      step(1);
      check("t3_restart", busy_b, 1);
      check("t3_restart_fall", fall_b, 1);
      en_b = 1'b0;
      step(14);
      check("t3_end_busy", busy_b, 0);

      // low_len=0 acts as 1; reset pulled mid-LOW.
      low_len = 16'd0; high_len = 16'd4; en_a = 1'b1; mark();
      expect_tick(T_FALL, 1);
      expect_tick(T_RISE, 4);
      expect_tick(T_SAMP, 2);
      step(1);
      check("t6_low", st_a, 1);
      check("t6_scl_low", scl_a, 0);
      step(1);
      check("t6_low_one_cycle", st_a, 2);
      check("t6_released", scl_a, 1);
      step(7);
      check("t6_low2", st_a, 1);
      check("t6_scl_low2", scl_a, 0);
      rstn = 1'b0;
      #1;
      check("t6_rst_scl", scl_a, 1);
      check("t6_rst_busy", busy_a, 0);
      check("t6_rst_ticks", {fall_a, data_a, rise_a, samp_a}, 0);
      check("t6_rst_counter", cnt_a, 0);
      check("t6_rst_state", st_a, 0);
      check("t6_rst_misc", {str_a, to_a}, 0);
      en_a = 1'b0;
      step(2);
      rstn = 1'b1;
      step(4);
      check("t6_after_busy", busy_a, 0);
      check_drained("t6_drained");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/i2c_scl_gen.md
I2C_SCL_GEN -- requirements
Module: i2c_scl_gen

Interface
REQ-001 SHALL have parameter DIV_LEN, default 16, width of phase-length inputs and counter.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of flops synchronising the sensed SCL line (minimum 2).
REQ-003 SHALL have parameter TO_LEN, default 20, width of stretch-timeout counter.
REQ-004 SHALL have ports:
- clk  in  1  single system clock; all logic on posedge.
- rstn  in  1  asynchronous, active-low reset.
- en  in  1  1 = generate SCL clocks; 0 = finish current period then idle.
- low_len  in  DIV_LEN  SCL low phase length in clk cycles.
- high_len  in  DIV_LEN  SCL high phase length in clk cycles, counted after release is observed.
- timeout_clr  in  1  clears sticky timeout.
- scl  inout  1  open-drain SCL; drives 0 or Z, never 1; sensed through synchroniser.
- busy  out  1  state != IDLE.
- fall_tick  out  1  one-cycle pulse on the first cycle SCL is driven low.
- data_tick  out  1  one-cycle pulse at low-phase midpoint (SDA change point).
- rise_tick  out  1  one-cycle pulse on entry to HIGH.
- sample_tick  out  1  one-cycle pulse at high-phase midpoint (SDA sample point).
- stretching  out  1  slave is holding SCL low past expected release.
- timeout  out  1  sticky stretch-timeout flag.
- counter  out  DIV_LEN  current phase counter.

Function
REQ-005 SHALL implement FSM states IDLE, LOW, HIGH_WAIT, HIGH.
REQ-006 SHALL drive scl low only from a registered drive-low flop set exactly when the state is LOW.
REQ-007 IDLE -> LOW SHALL occur when en=1, timeout=0 and synchronised scl=1; the fall_tick pulse SHALL coincide with the first LOW cycle.
REQ-008 On LOW entry, low_len and high_len SHALL be latched; a latched value of 0 SHALL be treated as 1; mid-period input changes SHALL take effect at the next LOW entry.
REQ-009 In LOW, counter SHALL count 0..L-1 (L = latched low_len); data_tick SHALL pulse at counter == L/2 (integer division); at counter == L-1 the next state SHALL be HIGH_WAIT with counter cleared.
REQ-010 In HIGH_WAIT, scl SHALL be released; a wait counter of width TO_LEN SHALL increment each cycle; on the first cycle synchronised scl=1, the next state SHALL be HIGH and rise_tick SHALL pulse on the first HIGH cycle.
REQ-011 stretching SHALL be 1 while in HIGH_WAIT with wait counter > SYNC_STAGES, else 0.
REQ-012 If the wait counter reaches all-ones, timeout SHALL set, the state SHALL go to IDLE and scl SHALL stay released.
REQ-013 timeout SHALL remain set until timeout_clr=1 or reset; while set, no new period SHALL start.
REQ-014 In HIGH, counter SHALL count 0..H-1 (H = latched high_len); sample_tick SHALL pulse at counter == H/2; at counter == H-1 the next state SHALL be LOW if en=1, else IDLE.
REQ-015 Clock synchronisation: if synchronised scl=0 during HIGH before H-1, the FSM SHALL go to LOW immediately (fall_tick pulses) and SHALL NOT pulse sample_tick if the midpoint was not yet reached.
REQ-016 Deasserting en during LOW or HIGH_WAIT SHALL NOT truncate the period; the FSM SHALL stop only at the end of HIGH, leaving SCL high.
REQ-017 All tick outputs SHALL be mutually exclusive and asserted for exactly one cycle.
REQ-018 counter SHALL be 0 in IDLE and HIGH_WAIT.

Reset
REQ-019 rstn=0 SHALL asynchronously force: state IDLE, scl=Z, busy=0, all ticks=0, stretching=0, timeout=0, counter=0, synchroniser flops=1, latched lengths=1.
REQ-020 Reset asserted mid-LOW SHALL release scl in the same cycle without waiting for a clock edge.

Verification
REQ-021 The bench SHALL run low_len=4, high_len=4, en=1 with a pull-up only: period = 4 + (SYNC_STAGES+1) + 4 = 11 cycles; data_tick at LOW count 2; sample_tick at HIGH count 2.
REQ-022 The bench SHALL hold the slave SCL low for 20 extra cycles: stretching=1 during the hold; rise_tick occurs SYNC_STAGES+1 cycles after release; no timeout.
REQ-023 The bench SHALL hold SCL low indefinitely with TO_LEN=4: timeout=1 after 15 HIGH_WAIT cycles; busy=0; en=1 does not restart until timeout_clr.
REQ-024 The bench SHALL drop en mid-LOW: the period completes through HIGH and the FSM ends in IDLE with scl=Z and no further fall_tick.
REQ-025 The bench SHALL have a second master pull SCL low at HIGH count 1 with high_len=6: the FSM goes to LOW, fall_tick pulses and sample_tick does not pulse.
REQ-026 The bench SHALL apply low_len=0 and pulse rstn mid-LOW: the LOW phase lasts 1 cycle; rstn=0 releases scl immediately and all outputs reach their reset values.
